switch_debouncer: RTL and testbench
===================================

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 Parameter: N, default 4, number of switch channels.
REQ-002 Parameter: DEBOUNCE_CYCLES, default 250000, consecutive stable clocks required to accept a new level; legal range 2..2^24.
REQ-003 Port: i_clk  input  1  system clock, all logic on rising edge.
REQ-004 Port: i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: i_switch  input  N  raw, asynchronous, bouncing switch levels.
REQ-006 Port: o_switch  output  N  debounced levels; feeds the switches-to-LEDs stage i_switch directly.
REQ-007 Port: o_rise  output  N  one-cycle pulse per channel when o_switch bit goes 0->1.
REQ-008 Port: o_fall  output  N  one-cycle pulse per channel when o_switch bit goes 1->0.

Function
REQ-009 Each channel SHALL pass i_switch through a two-flop synchronizer before any other logic; synchronizer latency exactly 2 clocks.
REQ-010 Each channel SHALL run an independent FSM with states IDLE (synced level equals o_switch, counter held at 0) and COUNT (synced level differs from o_switch).
REQ-011 IDLE->COUNT when synced level != o_switch; counter loads 1 on that cycle.
REQ-012 In COUNT, counter increments by 1 per clock while synced level != o_switch.
REQ-013 In COUNT, if synced level returns to o_switch (bounce), counter clears to 0 and FSM returns to IDLE next cycle; o_switch unchanged.
REQ-014 When counter reaches DEBOUNCE_CYCLES, o_switch bit SHALL toggle on that same edge, counter clears, FSM returns to IDLE.
REQ-015 Accept latency: o_switch changes exactly 2 + DEBOUNCE_CYCLES clocks after a clean i_switch step is sampled.
REQ-016 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1); counter SHALL never wrap.
REQ-017 o_rise/o_fall SHALL be registered, asserted for exactly one clock, the cycle after o_switch toggles; never both high on one bit.
REQ-018 Channels SHALL be fully independent; simultaneous changes on several bits are debounced in parallel with identical latency.
REQ-019 A glitch shorter than DEBOUNCE_CYCLES synced clocks SHALL produce no change on any output.

Reset
REQ-020 Asserting i_rst_n low SHALL, asynchronously, clear synchronizers, counters, o_switch, o_rise, o_fall to 0 and force all FSMs to IDLE.
REQ-021 Reset asserted mid-COUNT SHALL abort the count; no edge pulse is produced for the aborted change.
REQ-022 After release, a switch held high SHALL appear on o_switch 2 + DEBOUNCE_CYCLES clocks later, with one o_rise pulse.

Configuration
REQ-023 Macro SWITCH_DEBOUNCER_EDGE_EN: when defined, edge-pulse logic of REQ-017 is compiled in.
REQ-024 When SWITCH_DEBOUNCER_EDGE_EN is undefined, o_rise and o_fall remain ports but SHALL be constant 0 and no edge registers are built; o_switch behaviour unchanged.

Structure
REQ-025 Shared package switch_pkg SHALL hold the FSM state typedef (IDLE, COUNT) and the default DEBOUNCE_CYCLES constant.
REQ-026 Per-channel logic (synchronizer, FSM, counter, edge regs) SHALL live in sub-module debounce_bit, instantiated N times by a generate loop.

Verification (bench uses N=4, DEBOUNCE_CYCLES=8)
REQ-027 Reset, i_switch=4'b0000 -> o_switch=0, o_rise=o_fall=0 throughout.
REQ-028 Clean step i_switch 4'b0000->4'b0001 -> o_switch=4'b0001 exactly 10 clocks later; o_rise=4'b0001 for one clock after; o_fall=0.
REQ-029 Bit0 bounces 1 for 5 clocks then 0 -> o_switch stays 4'b0000; no pulses.
REQ-030 i_switch 4'b0000->4'b1010 simultaneously -> o_switch=4'b1010 after 10 clocks, o_rise=4'b1010 one clock; then ->4'b0000 gives o_fall=4'b1010.
REQ-031 i_rst_n low 4 clocks into a count on bit2 -> all outputs 0 immediately; after release with bit2 still high, o_switch=4'b0100 10 clocks later.
REQ-032 Build without SWITCH_DEBOUNCER_EDGE_EN, repeat REQ-028 -> o_switch identical, o_rise/o_fall constant 0.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared definitions for the switch debouncer: per-channel FSM state type and default debounce length.
package switch_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 250000;

endpackage

// File: rtl/debounce_bit.sv
// Single-channel debouncer: two-flop synchronizer, IDLE/COUNT FSM with stability counter, optional edge pulses.
// Edge-pulse registers exist only when SWITCH_DEBOUNCER_EDGE_EN is defined.
module debounce_bit
    import switch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_switch,
    output logic o_switch,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    // The toggle fires on the edge where the count would reach DEBOUNCE_CYCLES.
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_out;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_out_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_switch;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        case (r_state)
            IDLE: begin
                if (r_sync2 != r_out) begin
                    w_state_nxt = COUNT;
                    w_cnt_nxt   = CW'(1);
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            COUNT: begin
                if (r_sync2 == r_out) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_out_nxt   = ~r_out;
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_out   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
        end
    end

    assign o_switch = r_out;

`ifdef SWITCH_DEBOUNCER_EDGE_EN
    logic r_prev;
    logic r_rise;
    logic r_fall;

    // Pulses land one cycle after o_switch toggles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_prev <= r_out;
            r_rise <= r_out & ~r_prev;
            r_fall <= ~r_out & r_prev;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;
`else
    assign o_rise = 1'b0;
    assign o_fall = 1'b0;
`endif

endmodule

// File: rtl/switch_debouncer.sv
// N-channel switch debouncer top: one independent debounce_bit per channel.
// Define SWITCH_DEBOUNCER_EDGE_EN to build the o_rise/o_fall pulse logic; otherwise they are tied to 0.
module switch_debouncer
    import switch_pkg::*;
#(
    parameter int unsigned N               = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_switch,
    output logic [N-1:0] o_switch,
    output logic [N-1:0] o_rise,
    output logic [N-1:0] o_fall
);

    for (genvar g = 0; g < N; g++) begin : g_ch
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_switch(i_switch[g]),
            .o_switch(o_switch[g]),
            .o_rise  (o_rise[g]),
            .o_fall  (o_fall[g])
        );
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed self-checking bench for switch_debouncer with N=4, DEBOUNCE_CYCLES=8.
module tb_switch_debouncer;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw;
    logic [3:0] o_switch;
    logic [3:0] o_rise;
    logic [3:0] o_fall;

    int checks   = 0;
    int failures = 0;

`ifdef SWITCH_DEBOUNCER_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    switch_debouncer #(
        .N              (4),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_switch(sw),
        .o_switch(o_switch),
        .o_rise  (o_rise),
        .o_fall  (o_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] pe(input logic [3:0] v);
        return EDGE ? v : 4'b0000;
    endfunction

    initial begin
        rst_n = 1'b0;
        sw    = 4'b0000;
        #1;
        chk("rst_sw", o_switch, 4'b0000);
        chk("rst_rise", o_rise, 4'b0000);
        chk("rst_fall", o_fall, 4'b0000);
        edges(3);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            edges(1);
            chk("idle_sw", o_switch, 4'b0000);
            chk("idle_rise", o_rise, 4'b0000);
            chk("idle_fall", o_fall, 4'b0000);
        end

        // Clean step on bit0
        sw = 4'b0001;
        edges(9);
        chk("step_early", o_switch, 4'b0000);
        edges(1);
        chk("step_sw", o_switch, 4'b0001);
        chk("step_rise_same", o_rise, 4'b0000);
        edges(1);
        chk("step_rise", o_rise, pe(4'b0001));
        chk("step_fall", o_fall, 4'b0000);
        chk("step_sw_hold", o_switch, 4'b0001);
        edges(1);
        chk("step_rise_end", o_rise, 4'b0000);
        sw = 4'b0000;
        edges(9);
        chk("release_early", o_switch, 4'b0001);
        edges(1);
        chk("release_sw", o_switch, 4'b0000);
        edges(1);
        chk("release_fall", o_fall, pe(4'b0001));
        chk("release_rise", o_rise, 4'b0000);
        edges(1);
        chk("release_fall_end", o_fall, 4'b0000);

        // Glitch of 5 clocks on bit0
        sw = 4'b0001;
        edges(5);
        sw = 4'b0000;
        for (int i = 0; i < 14; i++) begin
            edges(1);
            chk("glitch_sw", o_switch, 4'b0000);
            chk("glitch_rise", o_rise, 4'b0000);
            chk("glitch_fall", o_fall, 4'b0000);
        end

        // Simultaneous bits 3 and 1
        sw = 4'b1010;
        edges(9);
        chk("multi_early", o_switch, 4'b0000);
        edges(1);
        chk("multi_sw", o_switch, 4'b1010);
        edges(1);
        chk("multi_rise", o_rise, pe(4'b1010));
        edges(1);
        chk("multi_rise_end", o_rise, 4'b0000);
        sw = 4'b0000;
        edges(10);
        chk("multi_rel_sw", o_switch, 4'b0000);
        edges(1);
        chk("multi_fall", o_fall, pe(4'b1010));
        chk("multi_fall_rise", o_rise, 4'b0000);
        edges(1);
        chk("multi_fall_end", o_fall, 4'b0000);

        // Reset in the middle of a count on bit2
        sw = 4'b0100;
        edges(6);
        rst_n = 1'b0;
        #1;
        chk("abort_sw", o_switch, 4'b0000);
        chk("abort_rise", o_rise, 4'b0000);
        edges(2);
        chk("abort_hold_sw", o_switch, 4'b0000);
        chk("abort_hold_fall", o_fall, 4'b0000);
        rst_n = 1'b1;
        edges(9);
        chk("post_rst_early", o_switch, 4'b0000);
        chk("post_rst_rise0", o_rise, 4'b0000);
        edges(1);
        chk("post_rst_sw", o_switch, 4'b0100);
        edges(1);
        chk("post_rst_rise", o_rise, pe(4'b0100));
        chk("post_rst_fall", o_fall, 4'b0000);
        edges(1);
        chk("post_rst_rise_end", o_rise, 4'b0000);

        sw = 4'b0000;
        edges(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
